// File: rtl/typedefs_pkg.sv
// rtl/typedefs_pkg.sv - shared types and constants for the instruction-fetch front end
package typedefs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // ADDI x0,x0,0: what decode sees before the first fetch lands
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, single-outstanding imem fetch FSM and decode field slicing
module fetch_unit
    import typedefs_pkg::*;
#(
    parameter int                    WIDTH      = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [WIDTH-1:0]      imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [WIDTH-1:0]      instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [6:0]            opcode,
    output logic [2:0]            funct3,
    output logic [6:0]            funct7,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  drop_q, drop_d;
    logic [WIDTH-1:0]      instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [ADDR_WIDTH-1:0] redirect_target;

    assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        if (redirect_valid) begin
            pc_d = redirect_target;
        end

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                // A grant that coincides with a redirect still produces a
                // response from memory, so it must be swallowed in WAIT.
                if (imem_gnt) begin
                    state_d = WAIT;
                    drop_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid || drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + ADDR_WIDTH'(4);
                        state_d    = HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || instr_ready) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            instr_q    <= WIDTH'(NOP_INSTR);
            instr_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    int checks   = 0;
    int failures = 0;

    logic        gnt_en;
    logic        pend;
    logic [31:0] pend_addr;

    fetch_unit #(
        .WIDTH     (32),
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0030_8133;
            32'h0000_0008: return 32'h00A0_0213;
            32'h0000_000C: return 32'h0000_0000;
            32'h0000_0040: return 32'h0040_0313;
            32'h0000_0100: return 32'h1230_0293;
            default:       return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Zero-wait memory: grant whenever requested, data on the following cycle.
    task automatic drive_mem();
        imem_rvalid = pend;
        imem_rdata  = pend ? mem_word(pend_addr) : 32'h0;
        imem_gnt    = gnt_en & imem_req;
        pend        = imem_gnt;
        pend_addr   = imem_addr;
    endtask

    task automatic set_gnt(input logic v);
        gnt_en    = v;
        imem_gnt  = v & imem_req;
        pend      = imem_gnt;
        pend_addr = imem_addr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_mem();
    endtask

    initial begin
        int          n;
        logic [31:0] held_instr;

        rst_n          = 1'b0;
        gnt_en         = 1'b1;
        pend           = 1'b0;
        pend_addr      = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;

        step();
        step();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_opcode", {25'h0, opcode}, 32'h13);
        check("rst_rd", {27'h0, rd}, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        rst_n = 1'b1;
        step();
        check("first_req", {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        n = 0;
        while (!instr_valid && n < 10) begin
            step();
            n++;
        end
        check("first_valid_latency", n, 32'd2);
        check("i0_instr", instr, 32'h0050_0093);
        check("i0_opcode", {25'h0, opcode}, 32'h13);
        check("i0_rd", {27'h0, rd}, 32'h1);
        check("i0_pc", instr_pc, 32'h0);

        step();
        check("i1_req", {31'h0, imem_req}, 32'h1);
        check("i1_addr", imem_addr, 32'h4);
        step();
        step();
        check("i1_valid", {31'h0, instr_valid}, 32'h1);
        check("i1_opcode", {25'h0, opcode}, 32'h33);
        check("i1_funct7", {25'h0, funct7}, 32'h0);
        check("i1_funct3", {29'h0, funct3}, 32'h0);
        check("i1_rs1", {27'h0, rs1}, 32'h1);
        check("i1_rs2", {27'h0, rs2}, 32'h3);
        check("i1_rd", {27'h0, rd}, 32'h2);
        check("i1_pc", instr_pc, 32'h4);

        // Backpressure in HOLD
        instr_ready = 1'b0;
        held_instr  = instr;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", {31'h0, instr_valid}, 32'h1);
            check("bp_instr", instr, held_instr);
            check("bp_pc", instr_pc, 32'h4);
            check("bp_req", {31'h0, imem_req}, 32'h0);
        end
        instr_ready = 1'b1;
        set_gnt(1'b0);
        step();
        check("bp_next_req", {31'h0, imem_req}, 32'h1);
        check("bp_next_addr", imem_addr, 32'h8);

        // Grant stall: four cycles in REQ without gnt
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_req", {31'h0, imem_req}, 32'h1);
            check("stall_addr", imem_addr, 32'h8);
        end
        set_gnt(1'b1);
        step();
        step();
        check("i2_valid", {31'h0, instr_valid}, 32'h1);
        check("i2_instr", instr, 32'h00A0_0213);
        check("i2_pc", instr_pc, 32'h8);

        // Redirect during WAIT, stale response arrives one cycle later
        step();
        check("i3_addr", imem_addr, 32'hC);
        step();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        check("rw_valid_a", {31'h0, instr_valid}, 32'h0);
        check("rw_req_a", {31'h0, imem_req}, 32'h0);
        step();
        check("rw_valid_b", {31'h0, instr_valid}, 32'h0);
        check("rw_req", {31'h0, imem_req}, 32'h1);
        check("rw_addr", imem_addr, 32'h100);
        step();
        check("rw_valid_c", {31'h0, instr_valid}, 32'h0);
        step();
        check("rw_valid_d", {31'h0, instr_valid}, 32'h1);
        check("rw_instr", instr, 32'h1230_0293);
        check("rw_pc", instr_pc, 32'h100);

        // Redirect in HOLD with instr_ready also high
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        check("rh_valid", {31'h0, instr_valid}, 32'h0);
        check("rh_req", {31'h0, imem_req}, 32'h1);
        check("rh_addr", imem_addr, 32'h40);

        // Reset while in WAIT; late response must be ignored
        step();
        imem_rvalid = 1'b0;
        pend        = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("mr_req", {31'h0, imem_req}, 32'h0);
        check("mr_addr", imem_addr, 32'h0);
        check("mr_instr", instr, 32'h0000_0013);
        check("mr_pc", instr_pc, 32'h0);
        step();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_BABE;
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        check("mr_first_req", {31'h0, imem_req}, 32'h1);
        check("mr_first_addr", imem_addr, 32'h0);
        check("mr_nop_hold", instr, 32'h0000_0013);
        check("mr_valid_a", {31'h0, instr_valid}, 32'h0);
        step();
        check("mr_valid_b", {31'h0, instr_valid}, 32'h0);
        check("mr_nop_wait", instr, 32'h0000_0013);
        step();
        check("mr_valid_c", {31'h0, instr_valid}, 32'h1);
        check("mr_instr_first", instr, 32'h0050_0093);
        check("mr_pc_first", instr_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
